// File: rtl/ex_div_sequencer.sv
// Purpose : multi-cycle restoring divider and sequencer for EX-stage DIV/DIVU/REM/REMU.
// Latency : W/BPC+2 cycles from the first s_start_i cycle to s_finished_o (1 cycle for
//           divide-by-zero and signed overflow).
// Backpressure: s_stall_i holds the result in DONE; it has no effect while iterating.
//           s_flush_i aborts the operation from any state.
//
// Ports:
//   s_clk_i       clock
//   s_rst_i       synchronous reset, active-high
//   s_start_i     EX holds a divide op (level)
//   s_func_i      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   s_operand1_i  dividend
//   s_operand2_i  divisor
//   s_stall_i     MA-stage stall; the result must stay in EX
//   s_flush_i     pipeline flush; abort the current op
//   s_busy_o      FSM not IDLE
//   s_finished_o  result valid this cycle (high only in DONE)
//   s_result_o    quotient or remainder, stable while s_finished_o=1
module ex_div_sequencer #(
  parameter int W   = 32,
  parameter int BPC = 1
) (
  input  logic         s_clk_i,
  input  logic         s_rst_i,
  input  logic         s_start_i,
  input  logic [1:0]   s_func_i,
  input  logic [W-1:0] s_operand1_i,
  input  logic [W-1:0] s_operand2_i,
  input  logic         s_stall_i,
  input  logic         s_flush_i,
  output logic         s_busy_o,
  output logic         s_finished_o,
  output logic [W-1:0] s_result_o
);

  localparam int STEPS = W / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(STEPS - 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e         state_q,    state_d;
  logic           is_rem_q,   is_rem_d;
  logic           quot_neg_q, quot_neg_d;
  logic           rem_neg_q,  rem_neg_d;
  // dvd_q starts as |dividend| and is shifted left each step; the quotient
  // bits enter at the LSB, so after the last step it holds |quotient|.
  logic [W-1:0]   dvd_q,      dvd_d;
  logic [W-1:0]   dvs_q,      dvs_d;
  logic [W-1:0]   acc_q,      acc_d;
  logic [CW-1:0]  cnt_q,      cnt_d;
  logic [W-1:0]   result_q,   result_d;

  // Operand decode for the start cycle.
  logic           op_signed;
  logic           op1_neg;
  logic           op2_neg;
  logic [W-1:0]   op1_abs;
  logic [W-1:0]   op2_abs;
  logic           div_zero;
  logic           signed_ovf;

  always_comb begin
    op_signed  = ~s_func_i[0];
    op1_neg    = op_signed & s_operand1_i[W-1];
    op2_neg    = op_signed & s_operand2_i[W-1];
    op1_abs    = op1_neg ? (-s_operand1_i) : s_operand1_i;
    op2_abs    = op2_neg ? (-s_operand2_i) : s_operand2_i;
    div_zero   = (s_operand2_i == '0);
    // Most-negative / -1 would overflow the quotient; answer it directly.
    signed_ovf = op_signed && (s_operand1_i == MIN_NEG) && (s_operand2_i == '1);
  end

  // BPC restoring steps per cycle. The partial remainder is compared and
  // subtracted in W+1 bits; the stored remainder always fits in W bits because
  // it is strictly smaller than the divisor after every step.
  logic [W-1:0]   step_acc;
  logic [W-1:0]   step_dvd;
  logic [W:0]     trial;
  logic           qbit;

  always_comb begin
    step_acc = acc_q;
    step_dvd = dvd_q;
    trial    = '0;
    qbit     = 1'b0;
    for (int b = 0; b < BPC; b++) begin
      trial = {step_acc, step_dvd[W-1]};
      if (trial >= {1'b0, dvs_q}) begin
        trial = trial - {1'b0, dvs_q};
        qbit  = 1'b1;
      end else begin
        qbit  = 1'b0;
      end
      step_acc = trial[W-1:0];
      step_dvd = {step_dvd[W-2:0], qbit};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    is_rem_d   = is_rem_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;

    if (s_flush_i) begin
      // Abort; a start request in the same cycle is dropped and the last
      // result is left untouched.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (s_start_i) begin
            is_rem_d   = s_func_i[1];
            quot_neg_d = op1_neg ^ op2_neg;
            rem_neg_d  = op1_neg;
            dvd_d      = op1_abs;
            dvs_d      = op2_abs;
            acc_d      = '0;
            cnt_d      = CNT_INIT;
            if (div_zero) begin
              // Remainder is the raw dividend, not its magnitude.
              result_d = s_func_i[1] ? s_operand1_i : '1;
              state_d  = ST_DONE;
            end else if (signed_ovf) begin
              result_d = s_func_i[1] ? '0 : MIN_NEG;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_CALC;
            end
          end
        end

        ST_CALC: begin
          acc_d = step_acc;
          dvd_d = step_dvd;
          if (cnt_q == '0) begin
            state_d = ST_FIXUP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        ST_FIXUP: begin
          if (is_rem_q) begin
            result_d = rem_neg_q ? (-acc_q) : acc_q;
          end else begin
            result_d = quot_neg_q ? (-dvd_q) : dvd_q;
          end
          state_d = ST_DONE;
        end

        ST_DONE: begin
          // The instruction leaves EX only when MA accepts it. A start level
          // seen here belongs to the op being retired, so it is ignored.
          if (!s_stall_i) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state_q    <= ST_IDLE;
      is_rem_q   <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_rem_q   <= is_rem_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  assign s_busy_o     = (state_q != ST_IDLE);
  assign s_finished_o = (state_q == ST_DONE);
  assign s_result_o   = result_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Bench for ex_div_sequencer: one instance with BPC=1 and one with BPC=2,
// sharing operands/func/stall/flush/reset but with separate start lines.
module tb_ex_div_sequencer;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic         start1;
  logic         start2;
  logic [1:0]   func;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         stall;
  logic         flush;
  logic         busy1, fin1;
  logic [W-1:0] res1;
  logic         busy2, fin2;
  logic [W-1:0] res2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  ex_div_sequencer #(.W(W), .BPC(1)) dut1 (
    .s_clk_i      (clk),
    .s_rst_i      (rst),
    .s_start_i    (start1),
    .s_func_i     (func),
    .s_operand1_i (op1),
    .s_operand2_i (op2),
    .s_stall_i    (stall),
    .s_flush_i    (flush),
    .s_busy_o     (busy1),
    .s_finished_o (fin1),
    .s_result_o   (res1)
  );

  ex_div_sequencer #(.W(W), .BPC(2)) dut2 (
    .s_clk_i      (clk),
    .s_rst_i      (rst),
    .s_start_i    (start2),
    .s_func_i     (func),
    .s_operand1_i (op1),
    .s_operand2_i (op2),
    .s_stall_i    (stall),
    .s_flush_i    (flush),
    .s_busy_o     (busy2),
    .s_finished_o (fin2),
    .s_result_o   (res2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, ran 500000 time units, required completion earlier");
    $fatal(1);
  end

  // Reference: language division with the two architectural special cases.
  function automatic logic [W-1:0] model(input logic [1:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    if (b == '0) begin
      r = f[1] ? a : '1;
    end else if (!f[0] && a == MIN_NEG && b == '1) begin
      r = f[1] ? '0 : MIN_NEG;
    end else begin
      case (f)
        2'b00:   r = $signed(a) / $signed(b);
        2'b01:   r = a / b;
        2'b10:   r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit sel, input logic [1:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    bit special;
    func = f;
    op1  = a;
    op2  = b;
    special = (b == '0) || (!f[0] && a == MIN_NEG && b == '1);
    exp_q.push_back(model(f, a, b));
    lat_q.push_back(special ? 1 : (W / (sel ? 2 : 1) + 2));
    if (sel) start2 = 1'b1;
    else     start1 = 1'b1;
  endtask

  // Wait for finished, pop the scoreboard, compare result and latency.
  // With leave=1 also step the DUT back to IDLE.
  task automatic wait_done(input bit sel, input string name, input bit leave);
    int           n;
    logic         f;
    logic [W-1:0] r;
    logic [W-1:0] exp;
    int           elat;
    n = 0;
    f = 1'b0;
    while (!f && n < 100) begin
      tick();
      n++;
      // Once the op is under way, scramble the inputs: only latched copies count.
      if (n == 1 && (sel ? busy2 : busy1)) begin
        op1  = $urandom;
        op2  = $urandom;
        func = 2'($urandom_range(0, 3));
      end
      f = sel ? fin2 : fin1;
    end
    r    = sel ? res2 : res1;
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    if (sel) start2 = 1'b0;
    else     start1 = 1'b0;
    checks++;
    if (!f) begin
      errors++;
      $display("FAIL %s timeout: finished not seen in %0d cycles, required after %0d", name, n, elat);
    end else begin
      checks++;
      if (n !== elat) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, n, elat);
      end
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL %s result: got %h, required %h", name, r, exp);
      end
    end
    if (leave) begin
      tick();
      checks++;
      if ((sel ? busy2 : busy1) !== 1'b0) begin
        errors++;
        $display("FAIL %s return_idle: busy=%b, required 0", name, sel ? busy2 : busy1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; stall = 1'b0; flush = 1'b0;
    func = 2'b00; op1 = '0; op2 = '0;
    repeat (3) tick();
    checks++;
    if ({busy1, fin1, res1} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b fin=%b res=%h, required 0 0 00000000", busy1, fin1, res1);
    end
    checks++;
    if ({busy2, fin2, res2} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs_bpc2: got busy=%b fin=%b res=%h, required 0 0 00000000", busy2, fin2, res2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    launch(0, 2'b01, 32'd100, 32'd7); wait_done(0, "divu_100_7", 1);
    launch(0, 2'b11, 32'd100, 32'd7); wait_done(0, "remu_100_7", 1);
    for (int i = 0; i < 4; i++) begin
      launch(0, 2'(1 + 2 * (i % 2)), $urandom, ($urandom >> (i * 7)) | 32'd1);
      wait_done(0, "unsigned_rand", 1);
    end
  endtask

  task automatic test_signed();
    launch(0, 2'b00, 32'hFFFF_FFF9, 32'd2); wait_done(0, "div_m7_2", 1);
    launch(0, 2'b10, 32'hFFFF_FFF9, 32'd2); wait_done(0, "rem_m7_2", 1);
    launch(0, 2'b00, 32'd7, 32'hFFFF_FFFE); wait_done(0, "div_7_m2", 1);
    for (int i = 0; i < 4; i++) begin
      launch(0, 2'(2 * (i % 2)), $urandom, ($urandom >> (i * 6)) | 32'd1);
      wait_done(0, "signed_rand", 1);
    end
  endtask

  task automatic test_special();
    launch(0, 2'b00, MIN_NEG, 32'hFFFF_FFFF);  wait_done(0, "div_ovf", 1);
    launch(0, 2'b10, MIN_NEG, 32'hFFFF_FFFF);  wait_done(0, "rem_ovf", 1);
    launch(0, 2'b01, 32'h1234_5678, 32'h0);     wait_done(0, "divu_by0", 1);
    launch(0, 2'b10, 32'd5, 32'h0);             wait_done(0, "rem_5_by0", 1);
    launch(0, 2'b10, 32'hFFFF_FFFB, 32'h0);     wait_done(0, "rem_neg_by0", 1);
    launch(0, 2'b00, 32'hFFFF_FFFB, 32'h0);     wait_done(0, "div_neg_by0", 1);
  endtask

  task automatic test_stall();
    launch(0, 2'b00, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, "stall_op", 0);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({fin1, res1} !== {1'b1, 32'hFFFF_FFFD}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got fin=%b res=%h, required 1 fffffffd", i, fin1, res1);
      end
      if (i == 3) stall = 1'b0;
      tick();
    end
    checks++;
    if ({busy1, fin1} !== 2'b00) begin
      errors++;
      $display("FAIL stall_release: got busy=%b fin=%b, required 0 0", busy1, fin1);
    end
  endtask

  task automatic test_flush();
    logic seen;
    func = 2'b01; op1 = 32'd100; op2 = 32'd7; start1 = 1'b1;
    repeat (10) tick();
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_calc: got busy=%b, required 1", busy1);
    end
    flush = 1'b1;
    tick();
    checks++;
    if ({busy1, fin1} !== 2'b00) begin
      errors++;
      $display("FAIL flush_abort: got busy=%b fin=%b, required 0 0", busy1, fin1);
    end
    flush = 1'b0;
    start1 = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | fin1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_finish: finished seen=%b, required 0", seen);
    end
  endtask

  task automatic test_reset_calc();
    func = 2'b01; op1 = 32'd100; op2 = 32'd7; start1 = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy1, fin1, res1} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_in_calc: got busy=%b fin=%b res=%h, required 0 0 00000000", busy1, fin1, res1);
    end
    rst = 1'b0;
    start1 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    launch(0, 2'b01, 32'd9, 32'd3);
    wait_done(0, "b2b_first", 0);
    // Keep start high through DONE with the next op's operands.
    start1 = 1'b1; func = 2'b01; op1 = 32'd8; op2 = 32'd2;
    tick();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got busy=%b, required 0", busy1);
    end
    launch(0, 2'b01, 32'd8, 32'd2);
    wait_done(0, "b2b_second", 1);
  endtask

  task automatic test_bpc2();
    launch(1, 2'b01, 32'd100, 32'd7);        wait_done(1, "bpc2_divu_100_7", 1);
    launch(1, 2'b11, 32'd100, 32'd7);        wait_done(1, "bpc2_remu_100_7", 1);
    launch(1, 2'b10, 32'hFFFF_FFF9, 32'd2);  wait_done(1, "bpc2_rem_m7_2", 1);
    launch(1, 2'b00, $urandom, 32'd12345);   wait_done(1, "bpc2_div_rand", 1);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_stall();
    test_flush();
    test_reset_calc();
    test_back_to_back();
    test_bpc2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
